// File: rtl/m_kitchen_timer_ctrl_if.sv
// Kitchen-timer controller bus: debounced buttons and 1 Hz tick in, display/buzzer/status out.
interface m_kitchen_timer_ctrl_if;
  logic       i_tick_1hz;
  logic       i_btn_min;
  logic       i_btn_sec;
  logic       i_btn_start;
  logic [7:0] o_min_bcd;
  logic [7:0] o_sec_bcd;
  logic       o_running;
  logic       o_alarm;
  logic       o_buzzer;
  logic       o_disp_en;
  logic [1:0] o_state;

  // Drives the controller inputs and observes its outputs
  modport master (
    output i_tick_1hz, i_btn_min, i_btn_sec, i_btn_start,
    input  o_min_bcd, o_sec_bcd, o_running, o_alarm, o_buzzer, o_disp_en, o_state
  );

  // The controller itself
  modport slave (
    input  i_tick_1hz, i_btn_min, i_btn_sec, i_btn_start,
    output o_min_bcd, o_sec_bcd, o_running, o_alarm, o_buzzer, o_disp_en, o_state
  );
endinterface

// File: rtl/m_kitchen_timer_ctrl.sv
// Kitchen-timer sequencer: BCD MM:SS set by buttons, 1 Hz countdown, timed alarm.
// Optional macro KTIMER_PAUSE_BLINK_EN: blinks the display at 1 Hz while paused.
module m_kitchen_timer_ctrl #(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic                    clk,
  input  logic                    n_reset,
  m_kitchen_timer_ctrl_if.slave   if_kt
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_min;
  logic [7:0]       r_sec;
  logic [7:0]       w_min_nxt;
  logic [7:0]       w_sec_nxt;
  logic             r_buzzer;
  logic             w_buzzer_nxt;
  logic [CNT_W-1:0] r_alarm_cnt;
  logic [CNT_W-1:0] w_alarm_cnt_nxt;
  logic [CNT_W-1:0] w_alarm_cnt_inc;
  logic             r_btn_min;
  logic             r_btn_sec;
  logic             r_btn_start;
  logic             w_ev_min;
  logic             w_ev_sec;
  logic             w_ev_start;
  logic [7:0]       w_run_min;
  logic [7:0]       w_run_sec;
  logic             w_run_zero;
`ifdef KTIMER_PAUSE_BLINK_EN
  logic             r_disp_en;
  logic             w_disp_en_nxt;
`endif

  // BCD increment with wrap to 00 after the given maximum
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v == max_v)         return 8'h00;
    else if (v[3:0] == 4'd9) return {4'(v[7:4] + 4'd1), 4'd0};
    else                    return {v[7:4], 4'(v[3:0] + 4'd1)};
  endfunction

  // BCD decrement; caller guarantees v != 00
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {4'(v[7:4] - 4'd1), 4'd9};
    else                return {v[7:4], 4'(v[3:0] - 4'd1)};
  endfunction

  // Rising-edge events: pressed now, released last clk
  assign w_ev_min   = if_kt.i_btn_min   & ~r_btn_min;
  assign w_ev_sec   = if_kt.i_btn_sec   & ~r_btn_sec;
  assign w_ev_start = if_kt.i_btn_start & ~r_btn_start;

  assign w_alarm_cnt_inc = r_alarm_cnt + CNT_W'(1);

  // One-second countdown step: borrow 59 seconds from the minutes when seconds are 00
  always_comb begin
    w_run_min = r_min;
    w_run_sec = r_sec;
    if (r_sec != 8'h00) begin
      w_run_sec = bcd_dec(r_sec);
    end else begin
      w_run_sec = 8'h59;
      w_run_min = bcd_dec(r_min);
    end
    w_run_zero = (w_run_min == 8'h00) && (w_run_sec == 8'h00);
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt     = r_state;
    w_min_nxt       = r_min;
    w_sec_nxt       = r_sec;
    w_buzzer_nxt    = 1'b0;
    w_alarm_cnt_nxt = r_alarm_cnt;
`ifdef KTIMER_PAUSE_BLINK_EN
    w_disp_en_nxt   = r_disp_en;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_ev_start && ((r_min != 8'h00) || (r_sec != 8'h00))) begin
          w_state_nxt = ST_RUN;
        end else begin
          if (w_ev_min) w_min_nxt = bcd_inc(r_min, 8'h99);
          if (w_ev_sec) w_sec_nxt = bcd_inc(r_sec, 8'h59);
        end
      end
      ST_RUN: begin
        if (w_ev_start) begin
          w_state_nxt = ST_PAUSE;
`ifdef KTIMER_PAUSE_BLINK_EN
          w_disp_en_nxt = 1'b0;
`endif
        end else if (if_kt.i_tick_1hz) begin
          w_min_nxt = w_run_min;
          w_sec_nxt = w_run_sec;
          if (w_run_zero) begin
            w_state_nxt     = ST_ALARM;
            w_alarm_cnt_nxt = '0;
            w_buzzer_nxt    = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (w_ev_start) begin
          w_state_nxt = ST_RUN;
`ifdef KTIMER_PAUSE_BLINK_EN
          w_disp_en_nxt = 1'b1;
`endif
        end else if (w_ev_min && w_ev_sec) begin
          w_state_nxt = ST_IDLE;
          w_min_nxt   = 8'h00;
          w_sec_nxt   = 8'h00;
`ifdef KTIMER_PAUSE_BLINK_EN
          w_disp_en_nxt = 1'b1;
`endif
        end else if (if_kt.i_tick_1hz) begin
`ifdef KTIMER_PAUSE_BLINK_EN
          w_disp_en_nxt = ~r_disp_en;
`endif
        end
      end
      ST_ALARM: begin
        w_buzzer_nxt = r_buzzer;
        if (w_ev_start) begin
          w_state_nxt  = ST_IDLE;
          w_buzzer_nxt = 1'b0;
        end else if (if_kt.i_tick_1hz) begin
          w_alarm_cnt_nxt = w_alarm_cnt_inc;
          if (w_alarm_cnt_inc == CNT_W'(ALARM_SECS)) begin
            w_state_nxt  = ST_IDLE;
            w_buzzer_nxt = 1'b0;
          end else begin
            w_buzzer_nxt = ~r_buzzer;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, time, alarm and button-history registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= ST_IDLE;
      r_min       <= 8'h00;
      r_sec       <= 8'h00;
      r_buzzer    <= 1'b0;
      r_alarm_cnt <= '0;
      r_btn_min   <= 1'b0;
      r_btn_sec   <= 1'b0;
      r_btn_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_min       <= w_min_nxt;
      r_sec       <= w_sec_nxt;
      r_buzzer    <= w_buzzer_nxt;
      r_alarm_cnt <= w_alarm_cnt_nxt;
      r_btn_min   <= if_kt.i_btn_min;
      r_btn_sec   <= if_kt.i_btn_sec;
      r_btn_start <= if_kt.i_btn_start;
    end
  end

`ifdef KTIMER_PAUSE_BLINK_EN
  // Display enable blinks only while paused
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_disp_en <= 1'b1;
    else          r_disp_en <= w_disp_en_nxt;
  end
  assign if_kt.o_disp_en = r_disp_en;
`else
  assign if_kt.o_disp_en = 1'b1;
`endif

  assign if_kt.o_min_bcd = r_min;
  assign if_kt.o_sec_bcd = r_sec;
  assign if_kt.o_buzzer  = r_buzzer;
  assign if_kt.o_state   = r_state;
  assign if_kt.o_running = (r_state == ST_RUN);
  assign if_kt.o_alarm   = (r_state == ST_ALARM);

endmodule

// File: tb/tb_m_kitchen_timer_ctrl.sv
// Self-checking bench for m_kitchen_timer_ctrl: directed table, corner sequences, random vs model.
module tb_m_kitchen_timer_ctrl;

  localparam int unsigned ALARM_SECS = 10;

  logic clk;
  logic n_reset;
  int   n_err;
  int   n_chk;

  m_kitchen_timer_ctrl_if u_if ();

  m_kitchen_timer_ctrl #(.ALARM_SECS(ALARM_SECS)) u_dut (
    .clk     (clk),
    .n_reset (n_reset),
    .if_kt   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time as plain minutes/seconds integers, state as 0..3
  int mm, ms, mst, mcnt;
  bit mbuz, mden, pm, ps, pst;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    mm = 0; ms = 0; mst = 0; mcnt = 0;
    mbuz = 1'b0; mden = 1'b1; pm = 1'b0; ps = 1'b0; pst = 1'b0;
  endtask

  task automatic model_step(input bit bm, input bit bs, input bit bst, input bit tk);
    bit em, es, est;
    int total;
    em = bm & !pm; es = bs & !ps; est = bst & !pst;
    pm = bm; ps = bs; pst = bst;
    case (mst)
      0: begin
        if (est && (mm * 60 + ms) != 0) mst = 1;
        else begin
          if (em) mm = (mm + 1) % 100;
          if (es) ms = (ms + 1) % 60;
        end
      end
      1: begin
        if (est) begin
          mst = 2;
`ifdef KTIMER_PAUSE_BLINK_EN
          mden = 1'b0;
`endif
        end else if (tk) begin
          total = mm * 60 + ms - 1;
          mm = total / 60; ms = total % 60;
          if (total == 0) begin mst = 3; mcnt = 0; mbuz = 1'b1; end
        end
      end
      2: begin
        if (est) begin mst = 1; mden = 1'b1; end
        else if (em && es) begin mst = 0; mm = 0; ms = 0; mden = 1'b1; end
        else if (tk) begin
`ifdef KTIMER_PAUSE_BLINK_EN
          mden = !mden;
`endif
        end
      end
      default: begin
        if (est) begin mst = 0; mbuz = 1'b0; end
        else if (tk) begin
          mcnt++;
          if (mcnt == int'(ALARM_SECS)) begin mst = 0; mbuz = 1'b0; end
          else mbuz = !mbuz;
        end
      end
    endcase
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".min"},     int'(u_if.o_min_bcd), int'(to_bcd(mm)));
    chk({tag, ".sec"},     int'(u_if.o_sec_bcd), int'(to_bcd(ms)));
    chk({tag, ".state"},   int'(u_if.o_state),   mst);
    chk({tag, ".running"}, int'(u_if.o_running), int'(mst == 1));
    chk({tag, ".alarm"},   int'(u_if.o_alarm),   int'(mst == 3));
    chk({tag, ".buzzer"},  int'(u_if.o_buzzer),  int'(mbuz));
    chk({tag, ".disp_en"}, int'(u_if.o_disp_en), int'(mden));
  endtask

  // One clock with the given input levels; model advances on the same edge
  task automatic cycle(input bit bm, input bit bs, input bit bst, input bit tk);
    @(negedge clk);
    u_if.i_btn_min = bm; u_if.i_btn_sec = bs; u_if.i_btn_start = bst; u_if.i_tick_1hz = tk;
    @(posedge clk);
    model_step(bm, bs, bst, tk);
    #1;
    check_all("cyc");
  endtask

  task automatic press(input bit bm, input bit bs, input bit bst, input bit tk);
    cycle(bm, bs, bst, tk);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit bm, bs, bst, tk;
    logic [7:0] em, es;
    logic [1:0] est;
    bit ebuz;
  } vec_t;

  vec_t vt[23];

  initial begin
    n_err = 0; n_chk = 0;
    u_if.i_btn_min = 1'b0; u_if.i_btn_sec = 1'b0; u_if.i_btn_start = 1'b0; u_if.i_tick_1hz = 1'b0;
    n_reset = 1'b0;
    model_reset();

    vt[0]  = '{0,1,0,0, 8'h00,8'h01, 2'd0, 0};
    vt[1]  = '{0,0,0,0, 8'h00,8'h01, 2'd0, 0};
    vt[2]  = '{0,1,0,0, 8'h00,8'h02, 2'd0, 0};
    vt[3]  = '{0,0,0,0, 8'h00,8'h02, 2'd0, 0};
    vt[4]  = '{0,1,0,0, 8'h00,8'h03, 2'd0, 0};
    vt[5]  = '{0,0,0,0, 8'h00,8'h03, 2'd0, 0};
    vt[6]  = '{1,0,0,0, 8'h01,8'h03, 2'd0, 0};
    vt[7]  = '{0,0,0,0, 8'h01,8'h03, 2'd0, 0};
    vt[8]  = '{1,0,0,0, 8'h02,8'h03, 2'd0, 0};
    vt[9]  = '{0,0,0,0, 8'h02,8'h03, 2'd0, 0};
    vt[10] = '{1,1,0,1, 8'h03,8'h04, 2'd0, 0};
    vt[11] = '{0,0,0,0, 8'h03,8'h04, 2'd0, 0};
    vt[12] = '{1,1,1,0, 8'h03,8'h04, 2'd1, 0};
    vt[13] = '{0,0,0,1, 8'h03,8'h03, 2'd1, 0};
    vt[14] = '{0,0,0,0, 8'h03,8'h03, 2'd1, 0};
    vt[15] = '{0,0,1,1, 8'h03,8'h03, 2'd2, 0};
    vt[16] = '{0,0,0,1, 8'h03,8'h03, 2'd2, 0};
    vt[17] = '{1,0,0,0, 8'h03,8'h03, 2'd2, 0};
    vt[18] = '{0,0,0,0, 8'h03,8'h03, 2'd2, 0};
    vt[19] = '{1,1,0,0, 8'h00,8'h00, 2'd0, 0};
    vt[20] = '{0,0,0,0, 8'h00,8'h00, 2'd0, 0};
    vt[21] = '{0,0,1,0, 8'h00,8'h00, 2'd0, 0};
    vt[22] = '{0,0,0,0, 8'h00,8'h00, 2'd0, 0};

    // Reset values
    #12;
    chk("rst.state",   int'(u_if.o_state),   0);
    chk("rst.min",     int'(u_if.o_min_bcd), 0);
    chk("rst.sec",     int'(u_if.o_sec_bcd), 0);
    chk("rst.buzzer",  int'(u_if.o_buzzer),  0);
    chk("rst.disp_en", int'(u_if.o_disp_en), 1);
    @(negedge clk);
    n_reset = 1'b1;

    // Directed table
    for (int i = 0; i < 23; i++) begin
      cycle(vt[i].bm, vt[i].bs, vt[i].bst, vt[i].tk);
      chk($sformatf("vec%0d.min", i),   int'(u_if.o_min_bcd), int'(vt[i].em));
      chk($sformatf("vec%0d.sec", i),   int'(u_if.o_sec_bcd), int'(vt[i].es));
      chk($sformatf("vec%0d.state", i), int'(u_if.o_state),   int'(vt[i].est));
      chk($sformatf("vec%0d.buz", i),   int'(u_if.o_buzzer),  int'(vt[i].ebuz));
    end

    // Holding a button gives one event
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold.min", int'(u_if.o_min_bcd), 8'h01);

    // Minute wrap 99 -> 00, second wrap 59 -> 00 without carry
    for (int i = 0; i < 98; i++) press(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap.min99", int'(u_if.o_min_bcd), 8'h99);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap.min00", int'(u_if.o_min_bcd), 8'h00);
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap.sec59", int'(u_if.o_sec_bcd), 8'h59);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap.sec00", int'(u_if.o_sec_bcd), 8'h00);
    chk("wrap.nocarry", int'(u_if.o_min_bcd), 8'h00);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("start0.state", int'(u_if.o_state), 0);

    // 01:00 countdown to alarm
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("cd.sec59", int'(u_if.o_sec_bcd), 8'h59);
    chk("cd.min00", int'(u_if.o_min_bcd), 8'h00);
    chk("cd.running", int'(u_if.o_running), 1);
    for (int i = 0; i < 58; i++) press(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("cd.alarm_state", int'(u_if.o_state), 3);
    chk("cd.alarm_buz", int'(u_if.o_buzzer), 1);
    chk("cd.alarm_sec", int'(u_if.o_sec_bcd), 0);

    // Alarm times out after ALARM_SECS ticks
    for (int k = 1; k <= 10; k++) begin
      press(1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("alm%0d.state", k), int'(u_if.o_state), (k == 10) ? 0 : 3);
      chk($sformatf("alm%0d.buz", k), int'(u_if.o_buzzer), (k < 10 && (k % 2) == 0) ? 1 : 0);
    end

    // Alarm cancelled by start, start beats same-cycle tick
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("cancel.pre", int'(u_if.o_state), 3);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1, 1'b1);
    chk("cancel.state", int'(u_if.o_state), 0);
    chk("cancel.buz", int'(u_if.o_buzzer), 0);

    // Pause / resume / clear gesture at 00:05
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b1);
    chk("pause.state", int'(u_if.o_state), 2);
    chk("pause.sec", int'(u_if.o_sec_bcd), 8'h05);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pause.frozen", int'(u_if.o_sec_bcd), 8'h05);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("resume.state", int'(u_if.o_state), 1);
    chk("resume.disp", int'(u_if.o_disp_en), 1);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b0, 1'b0);
    chk("clear.state", int'(u_if.o_state), 0);
    chk("clear.sec", int'(u_if.o_sec_bcd), 0);

    // Asynchronous reset mid-run at 00:30
    for (int i = 0; i < 30; i++) press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rrun.state", int'(u_if.o_state), 1);
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    model_reset();
    chk("arst.state", int'(u_if.o_state), 0);
    chk("arst.sec", int'(u_if.o_sec_bcd), 0);
    chk("arst.running", int'(u_if.o_running), 0);
    check_all("arst");
    @(negedge clk);
    n_reset = 1'b1;

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 12) == 0, ($urandom % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/m_kitchen_timer_ctrl.md
Name: m_kitchen_timer_ctrl

Overview:
Sequencer for the kitchen-timer datapath. It holds a BCD MM:SS value that the user sets with buttons, counts it down once per second, and raises a timed alarm when it reaches 00:00. It sits between the debounced switch outputs and 1 Hz tick on one side, and the seven-segment digit drivers and buzzer on the other.

Parameters:
ALARM_SECS, 10, number of tick_1hz pulses the alarm stays active before returning to IDLE (1..255)

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous, active-low reset
tick_1hz  in  1  one-clk-wide enable pulse, once per second
btn_min  in  1  debounced level, minute button (pressed = 1)
btn_sec  in  1  debounced level, second button (pressed = 1)
btn_start  in  1  debounced level, start/stop button (pressed = 1)
min_bcd  out  8  minutes, two BCD digits, 00..99
sec_bcd  out  8  seconds, two BCD digits, 00..59
running  out  1  1 while in RUN
alarm  out  1  1 while in ALARM
buzzer  out  1  alarm tone gate; toggles on each tick while in ALARM
disp_en  out  1  digit enable for the display mux
state  out  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3

Behaviour:
- Reset (async, n_reset=0): state=IDLE; min_bcd=8'h00; sec_bcd=8'h00; running=0; alarm=0; buzzer=0; disp_en=1; edge registers=0; alarm counter=0.
- Button events: each btn_* is registered once per clk. Event = current 1 and previous 0, lasting one clk. Holding a button produces exactly one event.
- All state and count updates occur on posedge clk. Outputs are registered except running/alarm, which decode state directly.
- IDLE:
  - min event: min_bcd += 1 in BCD, 99 -> 00 wrap.
  - sec event: sec_bcd += 1 in BCD, 59 -> 00 wrap, no carry into minutes.
  - min and sec events in the same cycle: both applied.
  - start event with time != 00:00 -> RUN; any min/sec event in that same cycle is ignored.
  - start event at 00:00: ignored, stay IDLE.
  - tick ignored.
- RUN:
  - On tick: if sec_bcd != 00, decrement sec in BCD (e.g. 10 -> 09). Otherwise sec_bcd = 59 and min_bcd decrements in BCD (e.g. 10 -> 09).
  - If the result is 00:00: enter ALARM on the same edge, clear the alarm counter, buzzer=1.
  - start event -> PAUSE. If a tick arrives in the same cycle, the start event wins and no decrement occurs.
  - min/sec events ignored.
- PAUSE:
  - Time frozen.
  - start event -> RUN.
  - min and sec events in the same cycle (clear gesture) -> IDLE with 00:00.
  - A single min or sec event is ignored.
- ALARM:
  - Time stays 00:00.
  - On each tick: alarm counter += 1, buzzer toggles.
  - When the counter reaches ALARM_SECS -> IDLE with buzzer=0.
  - start event -> IDLE immediately with buzzer=0; the start event takes priority over a same-cycle tick.
- buzzer is 0 in every state except ALARM.
- Reset asserted mid-operation: immediate return to the reset values, regardless of state.

Optional Feature:
KTIMER_PAUSE_BLINK_EN
- Defined: in PAUSE, disp_en toggles on each tick (1 Hz blink of the frozen time). Entering PAUSE sets disp_en=0. Leaving PAUSE forces disp_en=1.
- Not defined: disp_en is constant 1; no blink logic is synthesized.

Test Plan:
- Reset, then 3 sec events and 2 min events -> min_bcd=02, sec_bcd=03, state=IDLE. Hold btn_min for 100 clk -> exactly one increment, min_bcd=03.
- Set 00:59, apply 1 sec event -> sec_bcd=00, min_bcd=00. Set 99, apply 1 min event -> min_bcd=00. Start event at 00:00 -> state stays IDLE.
- Set 01:00, start, 1 tick -> 00:59, running=1. 59 more ticks -> 00:00 with state=ALARM and buzzer=1 on that same edge.
- In ALARM, 10 ticks (ALARM_SECS=10) -> buzzer toggles each tick, state=IDLE after the 10th. Repeat the run, then issue a start event after 3 ticks -> IDLE immediately, buzzer=0.
- RUN at 00:05: start event and tick in the same cycle -> PAUSE at 00:05. Ticks -> time frozen. Start event -> RUN. Start again -> PAUSE. Min+sec events together -> IDLE at 00:00.
- Assert n_reset mid-RUN at 00:30 -> all outputs at reset values asynchronously. With KTIMER_PAUSE_BLINK_EN defined: in PAUSE, disp_en = 0,1,0 over 3 ticks; after resume, disp_en=1.
